ahb_alu_slave: RTL and testbench
================================

AHB_ALU_SLAVE -- requirements
Module: ahb_alu_slave

Interface
REQ-001 Parameter ALU_LAT, default 2: cycles from start to result valid; legal range 1..7.
REQ-002 Parameter ADDR_W, default 8: number of low HADDR bits decoded.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 resetn  in  1  reset, synchronous and active-low.
REQ-005 hsel  in  1  slave select from the address decoder.
REQ-006 haddr  in  32  byte address; only bits [ADDR_W-1:0] are decoded.
REQ-007 htrans  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 hwrite  in  1  1=write, 0=read.
REQ-009 hsize  in  3  transfer size; only 3'b010 (word) is legal.
REQ-010 hwdata  in  32  write data, data phase.
REQ-011 hready  in  1  bus-level ready; an address phase is accepted only when it is 1.
REQ-012 hreadyout  out  1  slave ready; 0 inserts a wait state.
REQ-013 hresp  out  1  0=OKAY, 1=ERROR.
REQ-014 hrdata  out  32  read data, valid in the data phase when hreadyout=1.

Function
REQ-015 Accept an address phase when hsel=1, hready=1 and htrans[1]=1; register haddr, hwrite and hsize for the data phase.
REQ-016 Register map (word offsets): 0x00 OPA rw, 0x04 OPB rw, 0x08 CTRL rw, 0x0C RESULT ro, 0x10 STATUS ro; every other offset is unmapped.
REQ-017 CTRL[1:0] op: 00=ADD, 01=SUB (OPA-OPB), 10=AND, 11=OR; CTRL[2]=START, write-1 self-clearing, always reads 0.
REQ-018 Arithmetic modulo 2^32; STATUS[2] (carry/borrow) = bit 32 of the 33-bit ADD/SUB result, 0 for AND/OR.
REQ-019 Engine FSM: IDLE -> BUSY on a START write; BUSY holds ALU_LAT cycles and then -> DONE while loading RESULT; DONE -> BUSY on a new START, otherwise stays in DONE.
REQ-020 STATUS[0]=busy (state BUSY); STATUS[1]=done (state DONE); STATUS[31:3]=0.
REQ-021 A START write while BUSY is ignored, and the op completes with its original operands.
REQ-022 OPA/OPB/CTRL writes while BUSY update the registers, but the running op uses the operands latched at START.
REQ-023 A RESULT read while BUSY holds hreadyout=0 until the cycle RESULT is loaded, then returns the new value with OKAY.
REQ-024 All other legal accesses are zero-wait: hreadyout=1 and hresp=0 in the data phase.
REQ-025 A write to RESULT/STATUS, an access to an unmapped offset, or hsize!=010 gives a two-cycle ERROR: cycle 1 hreadyout=0, hresp=1; cycle 2 hreadyout=1, hresp=1; no register changes.
REQ-026 IDLE/BUSY transfers, or a cycle with hsel=0, give an OKAY zero-wait response and no side effects.
REQ-027 Back-to-back pipelined transfers (a write data phase overlapping the next address phase) are supported; a read of a register in the cycle after its write returns the new value.
REQ-028 hrdata=0 whenever the data phase is not a successful read.

Reset
REQ-029 When resetn=0 at a rising edge: OPA, OPB, CTRL and RESULT are set to 0, the FSM goes to IDLE, hreadyout=1, hresp=0, hrdata=0, and any pending data phase is dropped.
REQ-030 A reset during BUSY or mid-ERROR aborts the operation; the first accepted transfer after reset sees the reset values.

Structure
REQ-031 The shared package ahb_pkg holds the htrans/hsize encodings, the register offset constants, the ALU op enum and the FSM state enum.
REQ-032 A single sub-module, ahb_alu_core (operand latch, ALU_LAT counter, result/carry), is instantiated once; the AHB protocol logic stays in the top module.

Verification
REQ-033 Write OPA=1 and OPB=2, write CTRL=0x4 (ADD) -> STATUS reads 0x1 during BUSY, and ALU_LAT+1 cycles after START RESULT=3 and STATUS=0x2.
REQ-034 OPA=0, OPB=1, SUB -> RESULT=0xFFFFFFFF, STATUS=0x6.
REQ-035 Read RESULT in the cycle after START (ALU_LAT=2) -> hreadyout low for exactly 2 cycles, then hrdata holds the sum.
REQ-036 Read offset 0x14, a byte-size read of OPA, and a write to 0x0C -> each gives a two-cycle ERROR and the registers are unchanged.
REQ-037 Pipelined write OPA=0xA5 immediately followed by a read of OPA -> hrdata=0xA5, zero wait.
REQ-038 resetn low for 1 cycle during BUSY -> all registers read 0, STATUS=0, and no RESULT update follows.

Source files
------------

// File: rtl/ahb_pkg.sv
// -----------------------------------------------------------------------------
// ahb_pkg
// Shared definitions for the AHB ALU slave:
//   - AHB htrans / hsize encodings
//   - register word offsets of the slave's register map
//   - ALU operation enum (CTRL[1:0]) and engine FSM state enum
//   - register-select enum plus the offset decoder and transfer-type helper
// -----------------------------------------------------------------------------
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [31:0] OFF_OPA    = 32'h00;
    localparam logic [31:0] OFF_OPB    = 32'h04;
    localparam logic [31:0] OFF_CTRL   = 32'h08;
    localparam logic [31:0] OFF_RESULT = 32'h0C;
    localparam logic [31:0] OFF_STATUS = 32'h10;

    // CTRL[2] launches an operation; it is never stored.
    localparam int CTRL_START_BIT = 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ENG_IDLE = 2'b00,
        ENG_BUSY = 2'b01,
        ENG_DONE = 2'b10
    } eng_state_e;

    typedef enum logic [2:0] {
        SEL_OPA,
        SEL_OPB,
        SEL_CTRL,
        SEL_RESULT,
        SEL_STATUS,
        SEL_NONE
    } reg_sel_e;

    // Map a decoded byte offset onto a register; anything else is unmapped.
    function automatic reg_sel_e decode_offset(input logic [31:0] offset);
        reg_sel_e sel;
        case (offset)
            OFF_OPA:    sel = SEL_OPA;
            OFF_OPB:    sel = SEL_OPB;
            OFF_CTRL:   sel = SEL_CTRL;
            OFF_RESULT: sel = SEL_RESULT;
            OFF_STATUS: sel = SEL_STATUS;
            default:    sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    // Only NONSEQ and SEQ carry a real transfer.
    function automatic logic htrans_active(input logic [1:0] trans);
        logic active;
        case (trans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
        return active;
    endfunction

endpackage

// File: rtl/ahb_alu_core.sv
// -----------------------------------------------------------------------------
// ahb_alu_core
// Operation engine: latches operands and op on an accepted START, counts
// ALU_LAT busy cycles, then loads RESULT and the carry/borrow flag.
//   clk     in   clock
//   resetn  in   synchronous active-low reset
//   start   in   START strobe (ignored while BUSY)
//   op      in   operation to launch with this START
//   opa/opb in   operand values presented at START
//   state   out  engine state (IDLE / BUSY / DONE)
//   result  out  last completed result
//   carry   out  bit 32 of the last ADD/SUB (0 for AND/OR, cleared at START)
// -----------------------------------------------------------------------------
module ahb_alu_core
    import ahb_pkg::*;
#(
    parameter int ALU_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  alu_op_e     op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output eng_state_e  state,
    output logic [31:0] result,
    output logic        carry
);

    localparam logic [2:0] LAST_CNT = 3'(ALU_LAT - 1);

    eng_state_e  state_reg;
    eng_state_e  state_next;
    logic [2:0]  cnt_reg;
    logic [31:0] opa_lat_reg;
    logic [31:0] opb_lat_reg;
    alu_op_e     op_lat_reg;
    logic [31:0] result_reg;
    logic        carry_reg;
    logic        start_ok;
    logic        load;
    logic [32:0] alu_out;

    // A START arriving while an op runs is dropped so the op keeps its operands.
    assign start_ok = start && (state_reg != ENG_BUSY);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= ENG_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            ENG_IDLE: begin
                if (start) state_next = ENG_BUSY;
            end
            ENG_BUSY: begin
                if (cnt_reg == LAST_CNT) begin
                    state_next = ENG_DONE;
                    load       = 1'b1;
                end
            end
            ENG_DONE: begin
                if (start) state_next = ENG_BUSY;
            end
            default: state_next = ENG_IDLE;
        endcase
    end

    // 33-bit datapath so bit 32 is the carry (ADD) or borrow (SUB).
    always_comb begin
        alu_out = '0;
        case (op_lat_reg)
            OP_ADD:  alu_out = {1'b0, opa_lat_reg} + {1'b0, opb_lat_reg};
            OP_SUB:  alu_out = {1'b0, opa_lat_reg} - {1'b0, opb_lat_reg};
            OP_AND:  alu_out = {1'b0, opa_lat_reg & opb_lat_reg};
            OP_OR:   alu_out = {1'b0, opa_lat_reg | opb_lat_reg};
            default: alu_out = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_reg     <= '0;
            opa_lat_reg <= '0;
            opb_lat_reg <= '0;
            op_lat_reg  <= OP_ADD;
            result_reg  <= '0;
            carry_reg   <= 1'b0;
        end else begin
            if (start_ok) begin
                cnt_reg     <= '0;
                opa_lat_reg <= opa;
                opb_lat_reg <= opb;
                op_lat_reg  <= op;
                carry_reg   <= 1'b0;
            end else if (state_reg == ENG_BUSY) begin
                cnt_reg <= cnt_reg + 3'd1;
            end
            if (load) begin
                result_reg <= alu_out[31:0];
                carry_reg  <= alu_out[32];
            end
        end
    end

    assign state  = state_reg;
    assign result = result_reg;
    assign carry  = carry_reg;

endmodule

// File: rtl/ahb_alu_slave.sv
// -----------------------------------------------------------------------------
// ahb_alu_slave
// AHB-Lite slave exposing a small ALU: OPA, OPB, CTRL (rw), RESULT and
// STATUS (ro). Handles address/data pipelining, the two-cycle ERROR
// response, and wait states for a RESULT read while the engine is busy.
//   clk, resetn   clock, synchronous active-low reset
//   hsel..hready  AHB address-phase inputs, hwdata in the data phase
//   hreadyout     slave ready (0 = wait state)
//   hresp         0 = OKAY, 1 = ERROR
//   hrdata        read data, 0 unless a read completes successfully
// -----------------------------------------------------------------------------
module ahb_alu_slave
    import ahb_pkg::*;
#(
    parameter int ALU_LAT = 2,
    parameter int ADDR_W  = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    // Address phase decode
    logic     accept;
    reg_sel_e addr_sel;
    logic     addr_err;

    // Data phase state
    logic     dp_valid_reg;
    logic     dp_write_reg;
    reg_sel_e dp_sel_reg;
    logic     dp_err_reg;
    logic     err2_reg;

    // Register file
    logic [31:0] opa_reg;
    logic [31:0] opb_reg;
    alu_op_e     op_reg;

    // Engine outputs
    eng_state_e  eng_state;
    logic [31:0] eng_result;
    logic        eng_carry;

    logic err_first;
    logic rd_stall;
    logic wr_en;
    logic rd_ok;
    logic start;

    // Upper address bits and htrans[0] do not affect decoding.
    logic unused_bits;
    assign unused_bits = &{1'b0, haddr, htrans[0]};

    assign accept   = hsel && hready && htrans_active(htrans);
    assign addr_sel = decode_offset(32'(haddr[ADDR_W-1:0]));
    assign addr_err = (hsize != HSIZE_WORD) || (addr_sel == SEL_NONE) ||
                      (hwrite && ((addr_sel == SEL_RESULT) || (addr_sel == SEL_STATUS)));

    // First ERROR cycle drives hreadyout low; err2_reg marks the second.
    assign err_first = dp_valid_reg && dp_err_reg && !err2_reg;
    assign rd_stall  = dp_valid_reg && !dp_write_reg && !dp_err_reg &&
                       (dp_sel_reg == SEL_RESULT) && (eng_state == ENG_BUSY);

    assign hreadyout = !(err_first || rd_stall);
    assign hresp     = dp_valid_reg && dp_err_reg;

    assign wr_en = dp_valid_reg && dp_write_reg && !dp_err_reg && hready;
    assign rd_ok = dp_valid_reg && !dp_write_reg && !dp_err_reg && !rd_stall;
    assign start = wr_en && (dp_sel_reg == SEL_CTRL) && hwdata[CTRL_START_BIT];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            dp_valid_reg <= 1'b0;
            dp_write_reg <= 1'b0;
            dp_sel_reg   <= SEL_NONE;
            dp_err_reg   <= 1'b0;
            err2_reg     <= 1'b0;
            opa_reg      <= '0;
            opb_reg      <= '0;
            op_reg       <= OP_ADD;
        end else begin
            // The address phase is only sampled when the bus is ready.
            if (hready) begin
                dp_valid_reg <= accept;
                dp_write_reg <= hwrite;
                dp_sel_reg   <= addr_sel;
                dp_err_reg   <= addr_err;
            end
            err2_reg <= err_first;
            if (wr_en) begin
                case (dp_sel_reg)
                    SEL_OPA:  opa_reg <= hwdata;
                    SEL_OPB:  opb_reg <= hwdata;
                    SEL_CTRL: op_reg  <= alu_op_e'(hwdata[1:0]);
                    default:  ;
                endcase
            end
        end
    end

    // Register write lands on the same edge the next read's address is
    // sampled, so a read in the following data phase sees the new value.
    always_comb begin
        hrdata = '0;
        if (rd_ok) begin
            case (dp_sel_reg)
                SEL_OPA:    hrdata = opa_reg;
                SEL_OPB:    hrdata = opb_reg;
                SEL_CTRL:   hrdata = {30'b0, op_reg};
                SEL_RESULT: hrdata = eng_result;
                SEL_STATUS: hrdata = {29'b0, eng_carry,
                                      (eng_state == ENG_DONE),
                                      (eng_state == ENG_BUSY)};
                default:    hrdata = '0;
            endcase
        end
    end

    ahb_alu_core #(
        .ALU_LAT (ALU_LAT)
    ) u_core (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (alu_op_e'(hwdata[1:0])),
        .opa    (opa_reg),
        .opb    (opb_reg),
        .state  (eng_state),
        .result (eng_result),
        .carry  (eng_carry)
    );

endmodule

// File: tb/tb_ahb_alu_slave.sv
// -----------------------------------------------------------------------------
// tb_ahb_alu_slave
// Directed bench for ahb_alu_slave (ALU_LAT=2, ADDR_W=8). A single-master
// pipelined driver (pipe) issues transfers; each test task checks its own
// results against hand-computed values.
// -----------------------------------------------------------------------------
module tb_ahb_alu_slave;

    logic        clk;
    logic        resetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    int total;
    int bad;

    // Transfer list for the pipelined driver
    logic        p_wr    [8];
    logic [31:0] p_addr  [8];
    logic [2:0]  p_size  [8];
    logic [31:0] p_wd    [8];
    logic [31:0] p_rd    [8];
    logic        p_rsp   [8];
    logic        p_rsp0  [8];
    int          p_waits [8];

    ahb_alu_slave #(
        .ALU_LAT (2),
        .ADDR_W  (8)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata)
    );

    // Only slave on the bus: its ready is the bus ready.
    assign hready = hreadyout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs n transfers back to back. Called and returns 1 time unit after a
    // rising edge. Address i is driven while transfer i-1 is in its data phase.
    task automatic pipe(input int n);
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                hsel   = 1'b1;
                htrans = 2'b10;
                haddr  = p_addr[i];
                hwrite = p_wr[i];
                hsize  = p_size[i];
            end else begin
                hsel   = 1'b0;
                htrans = 2'b00;
                hwrite = 1'b0;
            end
            if (i > 0) begin
                hwdata       = p_wd[i-1];
                p_rsp0[i-1]  = hresp;
                p_waits[i-1] = 0;
                while (hreadyout !== 1'b1 && p_waits[i-1] < 20) begin
                    @(posedge clk); #1;
                    p_waits[i-1]++;
                end
                p_rd[i-1]  = hrdata;
                p_rsp[i-1] = hresp;
                $display("xfer %s addr=%h wdata=%h rdata=%h resp=%0d waits=%0d",
                         p_wr[i-1] ? "WR" : "RD", p_addr[i-1], p_wd[i-1],
                         p_rd[i-1], p_rsp[i-1], p_waits[i-1]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic set_xfer(input int i, input logic wr, input logic [31:0] a,
                            input logic [2:0] sz, input logic [31:0] d);
        p_wr[i]   = wr;
        p_addr[i] = a;
        p_size[i] = sz;
        p_wd[i]   = d;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        set_xfer(0, 1'b1, a, 3'b010, d);
        pipe(1);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d);
        set_xfer(0, 1'b0, a, 3'b010, 32'h0);
        pipe(1);
        d = p_rd[0];
    endtask

    task automatic test_reset;
        logic [31:0] v;
        resetn = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        total++; if (hreadyout !== 1'b1) begin bad++; $display("FAIL reset_hreadyout got=%b exp=1", hreadyout); end
        total++; if (hresp !== 1'b0) begin bad++; $display("FAIL reset_hresp got=%b exp=0", hresp); end
        total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL reset_hrdata got=%h exp=0", hrdata); end
        resetn = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            do_read(32'(k * 4), v);
            total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_reg off=%0h got=%h exp=0", k * 4, v); end
        end
    endtask

    task automatic test_add;
        logic [31:0] v;
        do_write(32'h00, 32'h1);
        do_write(32'h04, 32'h2);
        do_write(32'h08, 32'h4);
        do_read(32'h10, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL add_status_busy got=%h exp=1", v); end
        do_read(32'h0C, v);
        total++; if (v !== 32'h3) begin bad++; $display("FAIL add_result got=%h exp=3", v); end
        do_read(32'h10, v);
        total++; if (v !== 32'h2) begin bad++; $display("FAIL add_status_done got=%h exp=2", v); end
    endtask

    task automatic test_sub;
        logic [31:0] v;
        do_write(32'h00, 32'h0);
        do_write(32'h04, 32'h1);
        do_write(32'h08, 32'h5);
        do_read(32'h0C, v);
        total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sub_result got=%h exp=ffffffff", v); end
        total++; if (p_waits[0] !== 1) begin bad++; $display("FAIL sub_result_waits got=%0d exp=1", p_waits[0]); end
        do_read(32'h10, v);
        total++; if (v !== 32'h6) begin bad++; $display("FAIL sub_status got=%h exp=6", v); end
    endtask

    task automatic test_logic_ops;
        logic [31:0] v;
        do_write(32'h00, 32'h0000_F0F0);
        do_write(32'h04, 32'h0000_FF00);
        do_write(32'h08, 32'h6);
        do_read(32'h0C, v);
        total++; if (v !== 32'h0000_F000) begin bad++; $display("FAIL and_result got=%h exp=0000f000", v); end
        do_read(32'h10, v);
        total++; if (v !== 32'h2) begin bad++; $display("FAIL and_status got=%h exp=2", v); end
        do_write(32'h08, 32'h7);
        do_read(32'h08, v);
        total++; if (v !== 32'h3) begin bad++; $display("FAIL ctrl_readback got=%h exp=3", v); end
        do_read(32'h0C, v);
        total++; if (v !== 32'h0000_FFF0) begin bad++; $display("FAIL or_result got=%h exp=0000fff0", v); end
        do_write(32'h00, 32'hFFFF_FFFF);
        do_write(32'h04, 32'h1);
        do_write(32'h08, 32'h4);
        do_read(32'h0C, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL add_wrap_result got=%h exp=0", v); end
        do_read(32'h10, v);
        total++; if (v !== 32'h6) begin bad++; $display("FAIL add_wrap_status got=%h exp=6", v); end
    endtask

    task automatic test_result_stall;
        do_write(32'h00, 32'h5);
        do_write(32'h04, 32'h7);
        set_xfer(0, 1'b1, 32'h08, 3'b010, 32'h4);
        set_xfer(1, 1'b0, 32'h0C, 3'b010, 32'h0);
        pipe(2);
        total++; if (p_waits[1] !== 2) begin bad++; $display("FAIL stall_waits got=%0d exp=2", p_waits[1]); end
        total++; if (p_rd[1] !== 32'd12) begin bad++; $display("FAIL stall_result got=%h exp=0000000c", p_rd[1]); end
        total++; if (p_rsp[1] !== 1'b0) begin bad++; $display("FAIL stall_resp got=%b exp=0", p_rsp[1]); end
    endtask

    task automatic test_busy_writes;
        logic [31:0] v;
        do_write(32'h00, 32'd10);
        do_write(32'h04, 32'd3);
        // START ADD, then OPA and a SUB START land while the op is running.
        set_xfer(0, 1'b1, 32'h08, 3'b010, 32'h4);
        set_xfer(1, 1'b1, 32'h00, 3'b010, 32'd100);
        set_xfer(2, 1'b1, 32'h08, 3'b010, 32'h5);
        pipe(3);
        do_read(32'h0C, v);
        total++; if (v !== 32'd13) begin bad++; $display("FAIL busy_result got=%h exp=0000000d", v); end
        do_read(32'h10, v);
        total++; if (v !== 32'h2) begin bad++; $display("FAIL busy_status got=%h exp=2", v); end
        do_read(32'h00, v);
        total++; if (v !== 32'd100) begin bad++; $display("FAIL busy_opa got=%h exp=00000064", v); end
        do_read(32'h08, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL busy_ctrl got=%h exp=1", v); end
    endtask

    task automatic test_errors;
        logic [31:0] v;
        logic        ewr   [4];
        logic [31:0] eaddr [4];
        logic [2:0]  esize [4];
        ewr[0] = 1'b0; eaddr[0] = 32'h14; esize[0] = 3'b010;
        ewr[1] = 1'b0; eaddr[1] = 32'h00; esize[1] = 3'b000;
        ewr[2] = 1'b1; eaddr[2] = 32'h0C; esize[2] = 3'b010;
        ewr[3] = 1'b1; eaddr[3] = 32'h00; esize[3] = 3'b000;
        for (int k = 0; k < 4; k++) begin
            set_xfer(0, ewr[k], eaddr[k], esize[k], 32'h77);
            pipe(1);
            total++; if (p_rsp0[0] !== 1'b1 || p_waits[0] !== 1 || p_rsp[0] !== 1'b1 || p_rd[0] !== 32'h0)
                begin bad++; $display("FAIL err_case%0d rsp0=%b waits=%0d rsp=%b rdata=%h exp rsp0=1 waits=1 rsp=1 rdata=0",
                                      k, p_rsp0[0], p_waits[0], p_rsp[0], p_rd[0]); end
        end
        do_read(32'h0C, v);
        total++; if (v !== 32'd13) begin bad++; $display("FAIL err_result_kept got=%h exp=0000000d", v); end
        do_read(32'h00, v);
        total++; if (v !== 32'd100) begin bad++; $display("FAIL err_opa_kept got=%h exp=00000064", v); end
    endtask

    task automatic test_back_to_back;
        set_xfer(0, 1'b1, 32'h00, 3'b010, 32'hA5);
        set_xfer(1, 1'b0, 32'h00, 3'b010, 32'h0);
        set_xfer(2, 1'b1, 32'h04, 3'b010, 32'h5A);
        set_xfer(3, 1'b0, 32'h04, 3'b010, 32'h0);
        pipe(4);
        total++; if (p_rd[1] !== 32'hA5 || p_waits[1] !== 0) begin bad++; $display("FAIL b2b_opa got=%h waits=%0d exp=000000a5 waits=0", p_rd[1], p_waits[1]); end
        total++; if (p_rd[3] !== 32'h5A || p_waits[3] !== 0) begin bad++; $display("FAIL b2b_opb got=%h waits=%0d exp=0000005a waits=0", p_rd[3], p_waits[3]); end
    endtask

    task automatic test_idle_xfers;
        logic [31:0] v;
        logic       isel   [3];
        logic [1:0] itrans [3];
        isel[0] = 1'b0; itrans[0] = 2'b10;
        isel[1] = 1'b1; itrans[1] = 2'b00;
        isel[2] = 1'b1; itrans[2] = 2'b01;
        for (int k = 0; k < 3; k++) begin
            hsel = isel[k]; htrans = itrans[k]; haddr = 32'h00; hwrite = 1'b1; hsize = 3'b010;
            @(posedge clk); #1;
            hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hBAD;
            total++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin bad++; $display("FAIL idle_resp%0d ready=%b resp=%b exp ready=1 resp=0", k, hreadyout, hresp); end
            $display("idle case=%0d hsel=%b htrans=%b ready=%b resp=%b", k, isel[k], itrans[k], hreadyout, hresp);
            @(posedge clk); #1;
        end
        do_read(32'h00, v);
        total++; if (v !== 32'hA5) begin bad++; $display("FAIL idle_opa_kept got=%h exp=000000a5", v); end
    endtask

    task automatic test_reset_busy;
        logic [31:0] v;
        do_write(32'h00, 32'h1);
        do_write(32'h04, 32'h1);
        do_write(32'h08, 32'h4);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        for (int k = 0; k < 5; k++) begin
            do_read(32'(k * 4), v);
            total++; if (v !== 32'h0) begin bad++; $display("FAIL rstbusy_reg off=%0h got=%h exp=0", k * 4, v); end
        end
    endtask

    task automatic test_reset_error;
        logic [31:0] v;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h14; hwrite = 1'b0; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        total++; if ({hreadyout, hresp} !== 2'b01) begin bad++; $display("FAIL rsterr_first got=%b exp=01", {hreadyout, hresp}); end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        total++; if ({hreadyout, hresp} !== 2'b10 || hrdata !== 32'h0) begin bad++; $display("FAIL rsterr_after ready_resp=%b rdata=%h exp=10 0", {hreadyout, hresp}, hrdata); end
        do_read(32'h00, v);
        total++; if (v !== 32'h0 || p_waits[0] !== 0) begin bad++; $display("FAIL rsterr_opa got=%h waits=%0d exp=0 waits=0", v, p_waits[0]); end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        resetn = 1'b0;
        hsel   = 1'b0;
        haddr  = 32'h0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'b010;
        hwdata = 32'h0;
        @(posedge clk); #1;
        test_reset;
        test_add;
        test_sub;
        test_logic_ops;
        test_result_stall;
        test_busy_writes;
        test_errors;
        test_back_to_back;
        test_idle_xfers;
        test_reset_busy;
        test_reset_error;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
